// File: rtl/syscall_unit_pkg.sv
// Shared definitions for the memory-stage syscall unit: FSM encoding,
// SPIM service numbers and the ASCII characters the integer printer needs.
package syscall_unit_pkg;

   typedef enum logic [3:0] {
      IDLE,
      INT_SIGN,
      INT_CONV,
      INT_EMIT,
      STR_REQ,
      STR_WAIT,
      STR_EMIT,
      CHAR_EMIT,
      DONE,
      HALTED
   } state_t;

   localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
   localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
   localparam logic [31:0] SYS_EXIT       = 32'd10;
   localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;

endpackage

// File: rtl/syscall_unit_bin2bcd_seq.sv
// Sequential double-dabble: converts a 32-bit unsigned value to 10 BCD digits
// in exactly 32 cycles after start; done is high during the final cycle.
module bin2bcd_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] bin,
   output logic        done,
   output logic [39:0] bcd
);

   logic [31:0] shreg;
   logic [4:0]  cnt;
   logic        busy;
   logic [39:0] adj;

   function automatic logic [39:0] add3(input logic [39:0] b);
      logic [39:0] r;
      r = b;
      for (int i = 0; i < 10; i++) begin
         if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

   assign adj  = add3(bcd);
   assign done = busy && (cnt == 5'd31);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         cnt  <= 5'd0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= 5'd0;
      end else if (busy) begin
         cnt <= cnt + 5'd1;
         if (cnt == 5'd31) busy <= 1'b0;
      end
   end

   // Datapath is not reset; the result is held after the last shift until the next start.
   always_ff @(posedge clk) begin
      if (start) begin
         shreg <= bin;
         bcd   <= '0;
      end else if (busy) begin
         bcd   <= {adj[38:0], shreg[31]};
         shreg <= {shreg[30:0], 1'b0};
      end
   end

endmodule

// File: rtl/syscall_unit.sv
// Memory-stage syscall executor: print int/string/char and exit, emitting ASCII
// on a ready/valid stream and stalling the pipeline while a service runs.
module syscall_unit
   import syscall_unit_pkg::*;
#(
   parameter int MAX_STR_LEN = 1024,
   parameter bit BIG_ENDIAN  = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sysM,
   input  logic [31:0] regvM,
   input  logic [31:0] regaM,
   output logic        stallM,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   output logic [7:0]  out_data,
   input  logic        out_ready,
   output logic        halt,
   output logic        bad_sys
);

   localparam logic [31:0] MAX_LEN = 32'(MAX_STR_LEN);

   state_t      state, state_next;
   logic [31:0] val;
   logic [7:0]  chr;
   logic [31:0] ptr;
   logic [31:0] str_cnt;
   logic [31:0] word;
   logic [3:0]  dig;
   logic        started;

   logic        bcd_start, bcd_done;
   logic [39:0] bcd;
   logic [39:0] bcd_sh;
   logic [3:0]  cur_digit;
   logic [31:0] mag;
   logic [7:0]  str_byte;
   logic        skip, xfer, stall_svc, known_svc;

   function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] sel);
      logic [1:0] s;
      s = BIG_ENDIAN ? ~sel : sel;
      case (s)
         2'd0:    return w[7:0];
         2'd1:    return w[15:8];
         2'd2:    return w[23:16];
         default: return w[31:24];
      endcase
   endfunction

   assign stall_svc = (regvM == SYS_PRINT_INT) || (regvM == SYS_PRINT_STR) ||
                      (regvM == SYS_PRINT_CHAR);
   assign known_svc = stall_svc || (regvM == SYS_EXIT);
   assign mag       = val[31] ? (~val + 32'd1) : val;
   assign bcd_sh    = bcd >> {dig, 2'b00};
   assign cur_digit = bcd_sh[3:0];
   assign skip      = !started && (cur_digit == 4'd0) && (dig != 4'd0);
   assign str_byte  = pick_byte(word, ptr[1:0]);
   assign xfer      = out_valid && out_ready;
   assign halt      = (state == HALTED);

   bin2bcd_seq u_bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (bcd_start),
      .bin   (mag),
      .done  (bcd_done),
      .bcd   (bcd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         bad_sys <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE && sysM && !known_svc) bad_sys <= 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      stallM     = 1'b1;
      mem_req    = 1'b0;
      mem_addr   = 32'd0;
      out_valid  = 1'b0;
      out_data   = 8'd0;
      bcd_start  = 1'b0;
      case (state)
         IDLE: begin
            stallM = sysM && stall_svc;
            if (sysM) begin
               case (regvM)
                  SYS_PRINT_INT:  state_next = INT_SIGN;
                  SYS_PRINT_STR:  state_next = STR_REQ;
                  SYS_PRINT_CHAR: state_next = CHAR_EMIT;
                  SYS_EXIT:       state_next = HALTED;
                  default:        state_next = DONE;
               endcase
            end
         end
         INT_SIGN: begin
            if (val[31]) begin
               out_valid = 1'b1;
               out_data  = ASCII_MINUS;
            end
            if (!val[31] || out_ready) begin
               bcd_start  = 1'b1;
               state_next = INT_CONV;
            end
         end
         INT_CONV: if (bcd_done) state_next = INT_EMIT;
         INT_EMIT: begin
            // Leading zeros are skipped silently; digit 0 is always printed.
            if (!skip) begin
               out_valid = 1'b1;
               out_data  = ASCII_ZERO + {4'd0, cur_digit};
               if (out_ready && dig == 4'd0) state_next = DONE;
            end
         end
         STR_REQ: begin
            mem_req    = 1'b1;
            mem_addr   = {ptr[31:2], 2'b00};
            state_next = STR_WAIT;
         end
         STR_WAIT: begin
            mem_req  = 1'b1;
            mem_addr = {ptr[31:2], 2'b00};
            if (mem_ack) state_next = STR_EMIT;
         end
         STR_EMIT: begin
            if (str_byte == 8'd0) begin
               state_next = DONE;
            end else begin
               out_valid = 1'b1;
               out_data  = str_byte;
               if (out_ready) begin
                  if (str_cnt + 32'd1 == MAX_LEN) state_next = DONE;
                  else if (ptr[1:0] == 2'd3)     state_next = STR_REQ;
               end
            end
         end
         CHAR_EMIT: begin
            out_valid = 1'b1;
            out_data  = chr;
            if (out_ready) state_next = DONE;
         end
         DONE: begin
            stallM     = 1'b0;
            state_next = IDLE;
         end
         HALTED:  stallM = 1'b0;
         default: begin
            stallM     = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && sysM) begin
         val     <= regaM;
         chr     <= regaM[7:0];
         ptr     <= regaM;
         str_cnt <= 32'd0;
         dig     <= 4'd9;
         started <= 1'b0;
      end
      if (state == INT_EMIT) begin
         if (skip) begin
            dig <= dig - 4'd1;
         end else if (xfer) begin
            started <= 1'b1;
            if (dig != 4'd0) dig <= dig - 4'd1;
         end
      end
      if (state == STR_WAIT && mem_ack) word <= mem_rdata;
      if (state == STR_EMIT && xfer) begin
         ptr     <= ptr + 32'd1;
         str_cnt <= str_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_syscall_unit.sv
// Scoreboard bench for syscall_unit: expected characters and fetch addresses
// are queued when a syscall is issued and checked as the unit produces them.
module tb_syscall_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sysM = 1'b0;
   logic [31:0] regvM = 32'd0;
   logic [31:0] regaM = 32'd0;
   logic        stallM;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'hDEADBEEF;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready = 1'b1;
   logic        halt;
   logic        bad_sys;

   int total = 0;
   int bad = 0;
   int stall_len = 0;
   int lat = 0;
   bit rdy_toggle = 1'b0;
   logic [7:0]  exp_q[$];
   logic [31:0] addr_q[$];
   logic [31:0] mem [logic [31:0]];
   logic        prev_hold = 1'b0;
   logic [7:0]  prev_data = 8'd0;

   always #5 clk = ~clk;

   syscall_unit #(.MAX_STR_LEN(5), .BIG_ENDIAN(1'b0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sysM      (sysM),
      .regvM     (regvM),
      .regaM     (regaM),
      .stallM    (stallM),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .halt      (halt),
      .bad_sys   (bad_sys)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic push_str(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
   endtask

   // Present a syscall and hold it while stallM is high; returns on the first
   // falling edge with stallM low, leaving sysM asserted for the caller to replace.
   task automatic issue(input logic [31:0] v0, input logic [31:0] a0, input logic exp_stall);
      int n;
      @(posedge clk); #1;
      sysM = 1'b1; regvM = v0; regaM = a0;
      @(negedge clk);
      chk("acc_stall", stallM, exp_stall);
      n = 0;
      while (stallM && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("stall_release", stallM, 1'b0);
      stall_len = n;
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1;
      sysM = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_mem_req"}, mem_req, 1'b0);
      chk({tag, "_out_valid"}, out_valid, 1'b0);
      chk({tag, "_stallM"}, stallM, 1'b0);
      chk({tag, "_halt"}, halt, 1'b0);
      chk({tag, "_bad_sys"}, bad_sys, 1'b0);
   endtask

   always @(posedge clk) begin
      #1;
      if (rdy_toggle) out_ready = ~out_ready;
      else            out_ready = 1'b1;
   end

   // Memory responder: acknowledges on the third cycle of a held request.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_ack = 1'b0;
         lat = 0;
      end else begin
         #1;
         if (mem_ack) begin
            mem_ack = 1'b0;
            lat = 0;
         end else if (mem_req) begin
            lat++;
            if (lat == 3) begin
               mem_ack   = 1'b1;
               mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
               addr_q.push_back(mem_addr);
            end
         end else begin
            lat = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", out_data, prev_data);
         end
         if (out_valid && out_ready) begin
            chk("char_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) chk("char", out_data, exp_q.pop_front());
         end
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      mem[32'h1000] = 32'h00694800;
      mem[32'h1FFC] = 32'h62615A5A;
      mem[32'h2000] = 32'h66656463;

      #1;
      chk_reset_outputs("reset");
      chk("reset_out_data", out_data, 8'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Integer prints chained back to back: a second DONE cycle would show as a missed stall.
      push_str("0");
      issue(32'd1, 32'd0, 1'b1);
      chk("int_stall_len", stall_len >= 35, 1'b1);
      push_str("A");
      issue(32'd11, 32'h41, 1'b1);
      push_str("-123");
      issue(32'd1, 32'hFFFFFF85, 1'b1);
      push_str("-2147483648");
      issue(32'd1, 32'h80000000, 1'b1);
      push_str("2147483647");
      issue(32'd1, 32'h7FFFFFFF, 1'b1);
      idle(2);
      chk("int_q_empty", exp_q.size(), 0);

      // String under backpressure, NUL-terminated inside one word.
      rdy_toggle = 1'b1;
      addr_q.delete();
      push_str("Hi");
      issue(32'd4, 32'h1001, 1'b1);
      idle(4);
      rdy_toggle = 1'b0;
      chk("hi_q_empty", exp_q.size(), 0);
      chk("hi_fetches", addr_q.size(), 1);
      if (addr_q.size() >= 1) chk("hi_addr", addr_q[0], 32'h1000);

      // String crossing a word boundary, truncated at MAX_STR_LEN=5.
      addr_q.delete();
      push_str("abcde");
      issue(32'd4, 32'h1FFE, 1'b1);
      idle(6);
      chk("span_q_empty", exp_q.size(), 0);
      chk("span_fetches", addr_q.size(), 2);
      if (addr_q.size() >= 2) begin
         chk("span_addr0", addr_q[0], 32'h1FFC);
         chk("span_addr1", addr_q[1], 32'h2000);
      end

      // Unknown service.
      issue(32'd99, 32'd0, 1'b0);
      chk("bad_pre", bad_sys, 1'b0);
      idle(1);
      chk("bad_set", bad_sys, 1'b1);
      chk("bad_done_stall", stallM, 1'b0);
      idle(3);
      chk("bad_sticky", bad_sys, 1'b1);

      // Exit, then a later syscall must be ignored.
      issue(32'd10, 32'd0, 1'b0);
      chk("halt_pre", halt, 1'b0);
      idle(1);
      chk("halt_set", halt, 1'b1);
      chk("halt_stall", stallM, 1'b0);
      issue(32'd11, 32'h5A, 1'b0);
      idle(8);
      chk("halt_sticky", halt, 1'b1);
      chk("halt_no_req", mem_req, 1'b0);

      @(negedge clk);
      rst_n = 1'b0;
      #1 chk_reset_outputs("rst_halted");
      @(posedge clk); #1 rst_n = 1'b1;

      // Reset during STR_WAIT.
      @(posedge clk); #1;
      sysM = 1'b1; regvM = 32'd4; regaM = 32'h1001;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_req && n < 20);
      chk("wait_req_seen", mem_req, 1'b1);
      @(negedge clk);
      chk("in_str_wait", mem_req && !mem_ack, 1'b1);
      rst_n = 1'b0;
      sysM  = 1'b0;
      #1 chk_reset_outputs("rst_strwait");
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("strwait_no_req", mem_req, 1'b0);

      // Reset during INT_CONV.
      @(posedge clk); #1;
      sysM = 1'b1; regvM = 32'd1; regaM = 32'd5;
      repeat (10) @(negedge clk);
      chk("in_int_conv", stallM && !out_valid, 1'b1);
      rst_n = 1'b0;
      sysM  = 1'b0;
      #1 chk_reset_outputs("rst_intconv");
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("intconv_quiet", out_valid, 1'b0);

      push_str("A");
      issue(32'd11, 32'h41, 1'b1);
      idle(3);
      chk("final_q_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
